tff_state_monitor: RTL and testbench
====================================

Name: tff_state_monitor

Overview:
- Downstream consumer of the 2-bit T-flip-flop sequential circuit outputs A and B.
- Samples {A,B} each enabled clock and tracks transitions and dwell time.
- Detects the Gray-order sequence 00→01→11→10 and flags a state held too long.
- Feeds lab-board LEDs/counters and the verification bench as a checker.

Parameters:
- CNT_W, 8, width of trans_count; saturating.
- HOLD_W, 8, width of hold_count; saturating.
- STUCK_LIMIT, 16, hold_count value at which stuck asserts; must be ≤ 2^HOLD_W−1 and ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  sample enable; when 0, all state frozen.
- a_in  input  1  A output of upstream circuit (MSB of state).
- b_in  input  1  B output of upstream circuit (LSB).
- cur_state  output  2  last sampled {A,B}.
- trans_count  output  CNT_W  number of observed state changes.
- hold_count  output  HOLD_W  consecutive enabled samples with no change since last change.
- stuck  output  1  level; high while hold_count ≥ STUCK_LIMIT.
- seq_match  output  1  one-cycle pulse on completing 00→01→11→10.

Behaviour:
- Reset is asynchronous and active-high. It clears cur_state=00, trans_count=0, hold_count=0, stuck=0, seq_match=0, primed=0, and sets FSM=IDLE.
- All outputs are registered and update on the rising clk edge after the sample. Latency is 1 cycle.
- en=0: no register changes, and seq_match is driven 0 on that edge.
- Priming (en=1, primed=0):
  - cur_state ← {a_in,b_in}; primed ← 1.
  - No transition is counted; hold_count stays 0.
  - FSM ← S00 if sample is 00, else IDLE.
- Transition (en=1, primed=1, sample ≠ cur_state):
  - cur_state ← sample.
  - trans_count +1, saturating at 2^CNT_W−1.
  - hold_count ← 0 and stuck ← 0.
  - FSM steps as below.
- Hold (en=1, primed=1, sample = cur_state):
  - hold_count +1, saturating at 2^HOLD_W−1.
  - stuck ← 1 when the new hold_count ≥ STUCK_LIMIT.
  - FSM unchanged; seq_match 0.
- Sequence FSM (states IDLE, S00, S01, S11) advances only on transitions:
  - S00 with v=01 → S01.
  - S01 with v=11 → S11.
  - S11 with v=10 → IDLE, and seq_match=1 for one cycle.
  - Any other v: → S00 if v=00, else → IDLE.
- Overlap: after a match the FSM returns to IDLE. A following 00 restarts detection.
- Reset mid-sequence discards partial progress and requires re-priming.
- Simultaneous saturation of trans_count and stuck is allowed; each counter saturates independently.

Optional Feature:
- Macro: TFF_MON_ILLEGAL_EN.
- Defined:
  - Adds output illegal (1, one-cycle pulse) and output err_sticky (1, level).
  - A transition where both bits change at once (00↔11, 01↔10) pulses illegal and sets err_sticky.
  - err_sticky clears only on reset.
  - Counting and FSM behave identically.
- Undefined: neither port exists, and no extra logic is present.

Test Plan:
- Reset asserted with a_in,b_in=11, then released → all outputs 0 and FSM IDLE. The first enabled edge with 00 primes: cur_state=00, trans_count=0.
- Prime 00, then drive 01,11,10 on successive edges → trans_count=3, seq_match high exactly one cycle after the 10 edge, then low.
- Prime 01, then hold 01 for 16 enabled edges → hold_count=16 and stuck=1. Then drive 00 → hold_count=0, stuck=0, trans_count=1.
- Prime 00, drive 01, deassert en for 5 cycles while inputs toggle, reassert en with 11 then 10 → seq_match pulses. trans_count=3, with no counting during en=0.
- Alternate 00/01 for 300 transitions with CNT_W=8 → trans_count saturates at 255. Assert reset mid-run → trans_count=0 immediately, without waiting for a clk edge.
- With TFF_MON_ILLEGAL_EN: prime 00, drive 11 → illegal pulses 1 cycle, err_sticky=1, trans_count=1. Then drive 10 → err_sticky stays 1 until reset.

Source files
------------

// File: rtl/tff_state_monitor.sv
// ---------------------------------------------------------------------------
// tff_state_monitor
//
// Purpose:
//   Watches the two state bits {A,B} of an upstream T-flip-flop circuit. On
//   every enabled clock it samples the pair and tracks several things:
//     - how many state changes it has seen (saturating counter)
//     - how long the current state has been held (saturating counter)
//     - whether the state has been held for too long (stuck level)
//     - whether the Gray-order walk 00 -> 01 -> 11 -> 10 just completed
//       (seq_match, a one-cycle pulse)
//   The first enabled sample after reset only "primes" the monitor. It loads
//   cur_state without counting a transition, because there is no earlier
//   sample to compare it against.
//
// Optional feature (macro TFF_MON_ILLEGAL_EN):
//   When defined, the block adds the outputs illegal and err_sticky. They
//   flag transitions that flip both bits at once, which a Gray-stepping
//   counter should never produce. When the macro is undefined, neither the
//   ports nor the logic exist.
//
// Parameters:
//   CNT_W       width of trans_count (saturating)
//   HOLD_W      width of hold_count (saturating)
//   STUCK_LIMIT hold_count value at which stuck asserts;
//               1 <= STUCK_LIMIT <= 2**HOLD_W-1
//
// Ports:
//   clk          in   rising-edge system clock
//   reset        in   asynchronous, active-high reset
//   en           in   sample enable; when low, all state is frozen
//   a_in         in   A output of the upstream circuit (MSB of the state)
//   b_in         in   B output of the upstream circuit (LSB of the state)
//   cur_state    out  last sampled {A,B}
//   trans_count  out  number of observed state changes
//   hold_count   out  consecutive enabled samples without a change
//   stuck        out  high while hold_count >= STUCK_LIMIT
//   seq_match    out  one-cycle pulse on completing 00->01->11->10
//   illegal      out  (TFF_MON_ILLEGAL_EN) one-cycle pulse on a two-bit jump
//   err_sticky   out  (TFF_MON_ILLEGAL_EN) set by illegal, cleared by reset
// ---------------------------------------------------------------------------
module tff_state_monitor #(
  parameter int CNT_W       = 8,
  parameter int HOLD_W      = 8,
  parameter int STUCK_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              a_in,
  input  logic              b_in,
  output logic [1:0]        cur_state,
  output logic [CNT_W-1:0]  trans_count,
  output logic [HOLD_W-1:0] hold_count,
  output logic              stuck,
  output logic              seq_match
`ifdef TFF_MON_ILLEGAL_EN
  ,
  output logic              illegal,
  output logic              err_sticky
`endif
);

  // Sequence-detector progress: how much of 00->01->11->10 has been seen.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S00  = 2'd1,
    S01  = 2'd2,
    S11  = 2'd3
  } seq_state_t;

  localparam logic [CNT_W-1:0]  TRANS_MAX = {CNT_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] STUCK_THR = HOLD_W'(STUCK_LIMIT);

  seq_state_t        seq_state, seq_state_nxt;
  logic              primed, primed_nxt;
  logic [1:0]        cur_state_nxt;
  logic [CNT_W-1:0]  trans_count_nxt;
  logic [HOLD_W-1:0] hold_count_nxt;
  logic [HOLD_W-1:0] hold_inc;
  logic              stuck_nxt;
  logic              seq_match_nxt;
  logic [1:0]        sample;
  logic              changed;

`ifdef TFF_MON_ILLEGAL_EN
  logic              illegal_nxt;
  logic              err_sticky_nxt;
`endif

  assign sample   = {a_in, b_in};
  assign changed  = (sample != cur_state);
  // Saturating increment of the hold counter. This value is used both as
  // the new count and as the operand of the stuck comparison.
  assign hold_inc = (hold_count == HOLD_MAX) ? HOLD_MAX : hold_count + HOLD_W'(1);

  // Next-state and next-output logic for every register in the block.
  // The block has three branches:
  //   - priming: the first enabled sample after reset
  //   - transition: the sample differs from cur_state
  //   - hold: the sample equals cur_state
  // Pulse outputs default to 0, so an edge with en low also drives them low.
  always_comb begin
    seq_state_nxt   = seq_state;
    primed_nxt      = primed;
    cur_state_nxt   = cur_state;
    trans_count_nxt = trans_count;
    hold_count_nxt  = hold_count;
    stuck_nxt       = stuck;
    seq_match_nxt   = 1'b0;
`ifdef TFF_MON_ILLEGAL_EN
    illegal_nxt     = 1'b0;
    err_sticky_nxt  = err_sticky;
`endif

    if (en) begin
      if (!primed) begin
        // No earlier sample exists, so only load the state and arm the
        // detector if the walk could start right here.
        primed_nxt     = 1'b1;
        cur_state_nxt  = sample;
        hold_count_nxt = '0;
        seq_state_nxt  = (sample == 2'b00) ? S00 : IDLE;
      end else if (changed) begin
        cur_state_nxt   = sample;
        trans_count_nxt = (trans_count == TRANS_MAX) ? TRANS_MAX
                                                     : trans_count + CNT_W'(1);
        hold_count_nxt  = '0;
        stuck_nxt       = 1'b0;

        // The detector only advances on real transitions. Any value that
        // breaks the walk falls back to S00 when it is 00, because a fresh
        // walk starts from that state, and to IDLE otherwise.
        unique case (seq_state)
          S00: seq_state_nxt = (sample == 2'b01) ? S01 :
                               (sample == 2'b00) ? S00 : IDLE;
          S01: seq_state_nxt = (sample == 2'b11) ? S11 :
                               (sample == 2'b00) ? S00 : IDLE;
          S11: begin
            if (sample == 2'b10) begin
              seq_state_nxt = IDLE;
              seq_match_nxt = 1'b1;
            end else begin
              seq_state_nxt = (sample == 2'b00) ? S00 : IDLE;
            end
          end
          default: seq_state_nxt = (sample == 2'b00) ? S00 : IDLE;
        endcase

`ifdef TFF_MON_ILLEGAL_EN
        // A two-bit jump means both bits flipped on the same edge.
        if ((sample ^ cur_state) == 2'b11) begin
          illegal_nxt    = 1'b1;
          err_sticky_nxt = 1'b1;
        end
`endif
      end else begin
        hold_count_nxt = hold_inc;
        stuck_nxt      = (hold_inc >= STUCK_THR);
      end
    end
  end

  // State and output registers. The reset is asynchronous, so the
  // partial sequence progress and the primed flag are discarded at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_state   <= IDLE;
      primed      <= 1'b0;
      cur_state   <= 2'b00;
      trans_count <= '0;
      hold_count  <= '0;
      stuck       <= 1'b0;
      seq_match   <= 1'b0;
    end else begin
      seq_state   <= seq_state_nxt;
      primed      <= primed_nxt;
      cur_state   <= cur_state_nxt;
      trans_count <= trans_count_nxt;
      hold_count  <= hold_count_nxt;
      stuck       <= stuck_nxt;
      seq_match   <= seq_match_nxt;
    end
  end

`ifdef TFF_MON_ILLEGAL_EN
  // Registers for the illegal-jump flags. Only reset clears err_sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      illegal    <= illegal_nxt;
      err_sticky <= err_sticky_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_tff_state_monitor.sv
// ---------------------------------------------------------------------------
// tb_tff_state_monitor
//
// Self-checking bench for tff_state_monitor. It drives directed vectors and
// compares the outputs against expected values worked out by hand. Inputs
// change on the falling edge, and outputs are sampled 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_tff_state_monitor;

  logic       clk;
  logic       reset;
  logic       en;
  logic       a_in;
  logic       b_in;
  logic [1:0] cur_state;
  logic [7:0] trans_count;
  logic [7:0] hold_count;
  logic       stuck;
  logic       seq_match;
`ifdef TFF_MON_ILLEGAL_EN
  logic       illegal;
  logic       err_sticky;
`endif

  int errors = 0;
  int checks = 0;

  tff_state_monitor #(
    .CNT_W      (8),
    .HOLD_W     (8),
    .STUCK_LIMIT(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .a_in       (a_in),
    .b_in       (b_in),
    .cur_state  (cur_state),
    .trans_count(trans_count),
    .hold_count (hold_count),
    .stuck      (stuck),
    .seq_match  (seq_match)
`ifdef TFF_MON_ILLEGAL_EN
    ,
    .illegal    (illegal),
    .err_sticky (err_sticky)
`endif
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one vector on the falling edge and returns just after the
  // following rising edge, when the registered outputs are valid.
  task automatic applyStimulus(input logic e, input logic a, input logic b);
    @(negedge clk);
    en   = e;
    a_in = a;
    b_in = b;
    @(posedge clk);
    #1;
  endtask

  // Pulses reset between clock edges and checks that the counters clear at
  // once, before any rising edge occurs.
  task automatic pulseReset(input string tag);
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput({tag, "_trans"}, 32'(trans_count), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    a_in  = 1'b1;
    b_in  = 1'b1;
    $display("[TB] starting tff_state_monitor bench");

    // Reset asserted with 11 on the inputs: every output stays clear.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cur",   32'(cur_state),   0);
    checkOutput("rst_trans", 32'(trans_count), 0);
    checkOutput("rst_hold",  32'(hold_count),  0);
    checkOutput("rst_stuck", 32'(stuck),       0);
    checkOutput("rst_match", 32'(seq_match),   0);
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b0;

    // Prime with 00, then walk 01, 11, 10.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("prime_cur",   32'(cur_state),   0);
    checkOutput("prime_trans", 32'(trans_count), 0);
    checkOutput("prime_hold",  32'(hold_count),  0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("walk1_trans", 32'(trans_count), 1);
    checkOutput("walk1_match", 32'(seq_match),   0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("walk2_cur",   32'(cur_state),   3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("walk3_trans", 32'(trans_count), 3);
    checkOutput("walk3_match", 32'(seq_match),   1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("walk_after_match", 32'(seq_match),  0);
    checkOutput("walk_after_hold",  32'(hold_count), 1);

    // After a match a new 00 restarts detection. A broken walk that falls
    // back to 00 must still be able to complete.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("restart_nomatch", 32'(seq_match), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("restart_match", 32'(seq_match),   1);
    checkOutput("restart_trans", 32'(trans_count), 9);

    // Prime 01 and hold it: stuck asserts on the 16th held sample.
    pulseReset("rst2");
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (i == 14) begin
        checkOutput("hold15_cnt",   32'(hold_count), 15);
        checkOutput("hold15_stuck", 32'(stuck),      0);
      end
    end
    checkOutput("hold16_cnt",   32'(hold_count), 16);
    checkOutput("hold16_stuck", 32'(stuck),      1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("unstick_hold",  32'(hold_count),  0);
    checkOutput("unstick_stuck", 32'(stuck),       0);
    checkOutput("unstick_trans", 32'(trans_count), 1);

    // A gap with en low freezes everything, even while the inputs toggle.
    pulseReset("rst3");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, i[0], ~i[0]);
    end
    checkOutput("gap_trans", 32'(trans_count), 1);
    checkOutput("gap_cur",   32'(cur_state),   1);
    checkOutput("gap_hold",  32'(hold_count),  0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("gap_match", 32'(seq_match),   1);
    checkOutput("gap_trans3", 32'(trans_count), 3);

    // An en-low edge drives seq_match back to 0.
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("gap_match_clr", 32'(seq_match), 0);

    // 300 alternating transitions: trans_count saturates at 255.
    pulseReset("rst4");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, (i % 2) == 0);
      if (i == 253) checkOutput("sat_254", 32'(trans_count), 254);
      if (i == 254) checkOutput("sat_255", 32'(trans_count), 255);
    end
    checkOutput("sat_end", 32'(trans_count), 255);
    pulseReset("rst_async");

`ifdef TFF_MON_ILLEGAL_EN
    // A two-bit jump 00 -> 11 pulses illegal and sets the sticky error.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ill_prime", 32'(illegal), 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("ill_pulse",  32'(illegal),     1);
    checkOutput("ill_sticky", 32'(err_sticky),  1);
    checkOutput("ill_trans",  32'(trans_count), 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ill_pulse_end", 32'(illegal),    0);
    checkOutput("ill_sticky_hold", 32'(err_sticky), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("ill_sticky_rst", 32'(err_sticky), 0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
